// File: rtl/lcd_button_ctrl.sv
// rtl/lcd_button_ctrl.sv - front-panel button controller feeding config updates to the SPI LCD
//
// Synchronises and debounces the brightness and colour buttons, keeps the brightness,
// colour and screen-power shadow state, and offers coalesced config updates on a
// valid/ready handshake.
// Optional feature macro: BTN_AUTO_REPEAT_EN (colour auto-repeat while held).
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   bright_push     raw brightness button (active-high, asynchronous)
//   color_push      raw colour button (active-high, asynchronous)
//   screen_power    LCD supply enable
//   cfg_valid       config update offered
//   cfg_ready       SPI controller accepts the update
//   cfg_bright      brightness payload
//   cfg_color       colour payload
//   cfg_power       power payload
module lcd_button_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 50_000,
    parameter int LONG_PRESS_CYCLES = 24_000_000,
    parameter int BRIGHT_LEVELS     = 8,
    parameter int COLOR_COUNT       = 4,
    parameter int REPEAT_CYCLES     = 6_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             bright_push,
    input  logic                             color_push,
    output logic                             screen_power,
    output logic                             cfg_valid,
    input  logic                             cfg_ready,
    output logic [$clog2(BRIGHT_LEVELS)-1:0] cfg_bright,
    output logic [$clog2(COLOR_COUNT)-1:0]   cfg_color,
    output logic                             cfg_power
);
    localparam int BW = $clog2(BRIGHT_LEVELS);
    localparam int CW = $clog2(COLOR_COUNT);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {BOOT, IDLE, SEND} state_t;

    // Index 0 = bright, index 1 = colour
    logic [1:0]    raw, sync1, sync2, db, db_q;
    logic [DW-1:0] deb_cnt [2];

    assign raw = {color_push, bright_push};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]      <= ~db[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic b_rel, c_press;
    assign b_rel   = ~db[0] & db_q[0];
    assign c_press = db[1] & ~db_q[1];

    // Bright hold: the long-press event fires once and suppresses the following release
    logic [HW-1:0] b_hold;
    logic          b_long_done, b_long, b_short;

    assign b_long  = db[0] & ~b_long_done & (b_hold == HW'(LONG_PRESS_CYCLES - 1));
    assign b_short = b_rel & ~b_long_done;

    always_ff @(posedge clk) begin
        if (reset || !db[0]) begin
            b_hold      <= '0;
            b_long_done <= 1'b0;
        end else begin
            if (b_hold != HW'(LONG_PRESS_CYCLES - 1)) b_hold <= b_hold + HW'(1);
            if (b_long) b_long_done <= 1'b1;
        end
    end

    logic c_step;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [HW-1:0] c_hold;
    logic [RW-1:0] rep_cnt;
    logic          c_long, c_long_fire, c_rep_fire;

    assign c_long_fire = db[1] & ~c_long & (c_hold == HW'(LONG_PRESS_CYCLES - 1));
    assign c_rep_fire  = db[1] & c_long & (rep_cnt == RW'(REPEAT_CYCLES - 1));
    assign c_step      = c_press | c_long_fire | c_rep_fire;

    always_ff @(posedge clk) begin
        if (reset || !db[1]) begin
            c_hold  <= '0;
            c_long  <= 1'b0;
            rep_cnt <= '0;
        end else begin
            if (c_hold != HW'(LONG_PRESS_CYCLES - 1)) c_hold <= c_hold + HW'(1);
            if (c_long_fire) begin
                c_long  <= 1'b1;
                rep_cnt <= '0;
            end else if (c_long) begin
                rep_cnt <= c_rep_fire ? '0 : rep_cnt + RW'(1);
            end
        end
    end
`else
    assign c_step = c_press;
`endif

    // Shadow state; with power off only the bright long press gets through
    logic [BW-1:0] sh_bright;
    logic [CW-1:0] sh_color;
    logic          sh_power, sh_chg, apply_any;

    assign apply_any    = b_long | (sh_power & (b_short | c_step));
    assign screen_power = sh_power;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_bright <= BW'(BRIGHT_LEVELS - 1);
            sh_color  <= '0;
            sh_power  <= 1'b1;
            sh_chg    <= 1'b0;
        end else begin
            sh_chg <= apply_any;
            if (b_long) sh_power <= ~sh_power;
            if (sh_power && b_short) sh_bright <= sh_bright + BW'(1);
            if (sh_power && c_step)  sh_color  <= sh_color + CW'(1);
        end
    end

    // Update FSM: coalesces changes, last value wins
    state_t state, state_nxt;
    logic   dirty, dirty_nxt, load;

    always_comb begin
        state_nxt = state;
        dirty_nxt = dirty;
        load      = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = SEND;
                load      = 1'b1;
                dirty_nxt = 1'b0;
            end
            IDLE: begin
                if (sh_chg) begin
                    state_nxt = SEND;
                    load      = 1'b1;
                end
            end
            SEND: begin
                if (cfg_ready) begin
                    if (dirty || sh_chg) begin
                        load      = 1'b1;
                        dirty_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (sh_chg) begin
                    dirty_nxt = 1'b1;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            dirty      <= 1'b0;
            cfg_bright <= BW'(BRIGHT_LEVELS - 1);
            cfg_color  <= '0;
            cfg_power  <= 1'b1;
        end else begin
            state <= state_nxt;
            dirty <= dirty_nxt;
            if (load) begin
                cfg_bright <= sh_bright;
                cfg_color  <= sh_color;
                cfg_power  <= sh_power;
            end
        end
    end

    assign cfg_valid = (state == SEND);

endmodule

// File: tb/tb_lcd_button_ctrl.sv
// tb/tb_lcd_button_ctrl.sv - scoreboard bench for lcd_button_ctrl
module tb_lcd_button_ctrl;
    logic       clk = 1'b0;
    logic       reset, bright_push, color_push, cfg_ready;
    logic       screen_power, cfg_valid, cfg_power;
    logic [2:0] cfg_bright;
    logic [1:0] cfg_color;

    int vectors = 0;
    int errors  = 0;

    // Expected beat: {bright[2:0], color[1:0], power}
    logic [5:0] exp_q [$];

    lcd_button_ctrl #(
        .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(32), .BRIGHT_LEVELS(8),
        .COLOR_COUNT(4), .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .bright_push(bright_push), .color_push(color_push),
        .screen_power(screen_power), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_bright(cfg_bright), .cfg_color(cfg_color), .cfg_power(cfg_power)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc(1);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic push_exp(input logic [2:0] b, input logic [1:0] c, input logic p);
        exp_q.push_back({b, c, p});
    endtask

    always @(negedge clk) begin
        if (!reset && cfg_valid && cfg_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {cfg_bright, cfg_color, cfg_power}, 32'hffff);
            end else begin
                check("beat", {cfg_bright, cfg_color, cfg_power}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; bright_push = 1'b0; color_push = 1'b0; cfg_ready = 1'b1;
        cyc(3);
        check("rst_valid", cfg_valid, 0);
        check("rst_screen", screen_power, 1);
        check("rst_bright", cfg_bright, 7);
        check("rst_color", cfg_color, 0);
        check("rst_power", cfg_power, 1);

        // Boot pushes the reset configuration once
        push_exp(3'd7, 2'd0, 1'b1);
        reset = 1'b0;
        cyc(5);
        drain(20);
        check("boot_screen", screen_power, 1);

        // Two-cycle glitch must not debounce
        color_push = 1'b1; cyc(2); color_push = 1'b0;
        cyc(20);
        check("glitch_color", cfg_color, 0);
        check("glitch_valid", cfg_valid, 0);

        // Short bright press wraps 7 -> 0
        push_exp(3'd0, 2'd0, 1'b1);
        bright_push = 1'b1; cyc(10); bright_push = 1'b0;
        cyc(20);
        drain(20);
        check("short_bright", cfg_bright, 0);

        // Long press powers off; release ignored; colour press discarded
        push_exp(3'd0, 2'd0, 1'b0);
        bright_push = 1'b1; cyc(40); bright_push = 1'b0;
        cyc(20);
        drain(20);
        check("long_off_screen", screen_power, 0);
        check("long_off_bright", cfg_bright, 0);
        color_push = 1'b1; cyc(10); color_push = 1'b0;
        cyc(20);
        check("off_color", cfg_color, 0);
        check("off_valid", cfg_valid, 0);

        // Power back on
        push_exp(3'd0, 2'd0, 1'b1);
        bright_push = 1'b1; cyc(40); bright_push = 1'b0;
        cyc(20);
        drain(20);
        check("long_on_screen", screen_power, 1);

        // Backpressure: three colour presses coalesce into two beats
        cfg_ready = 1'b0;
        push_exp(3'd0, 2'd1, 1'b1);
        push_exp(3'd0, 2'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            color_push = 1'b1; cyc(10); color_push = 1'b0; cyc(10);
        end
        cyc(10);
        check("bp_valid", cfg_valid, 1);
        check("bp_color", cfg_color, 1);
        cyc(5);
        check("bp_color_stable", cfg_color, 1);
        cfg_ready = 1'b1;
        drain(20);
        cyc(3);
        check("bp_valid_drop", cfg_valid, 0);
        check("bp_color_final", cfg_color, 3);

        // Reset while an update is pending abandons it
        cfg_ready = 1'b0;
        color_push = 1'b1; cyc(10); color_push = 1'b0;
        cyc(15);
        check("pend_valid", cfg_valid, 1);
        check("pend_color", cfg_color, 0);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_valid", cfg_valid, 0);
        check("mid_rst_screen", screen_power, 1);
        check("mid_rst_bright", cfg_bright, 7);
        check("mid_rst_color", cfg_color, 0);
        check("mid_rst_power", cfg_power, 1);
        cyc(2);
        cfg_ready = 1'b1;
        push_exp(3'd7, 2'd0, 1'b1);
        reset = 1'b0;
        cyc(5);
        drain(20);

`ifdef BTN_AUTO_REPEAT_EN
        // Press, long threshold, then two repeats: 0 -> 1 -> 2 -> 3 -> 0
        push_exp(3'd7, 2'd1, 1'b1);
        push_exp(3'd7, 2'd2, 1'b1);
        push_exp(3'd7, 2'd3, 1'b1);
        push_exp(3'd7, 2'd0, 1'b1);
        color_push = 1'b1; cyc(48); color_push = 1'b0;
        cyc(20);
        drain(20);
        check("repeat_color", cfg_color, 0);
`else
        // Long colour hold still gives a single step
        push_exp(3'd7, 2'd1, 1'b1);
        color_push = 1'b1; cyc(48); color_push = 1'b0;
        cyc(20);
        drain(20);
        check("hold_color", cfg_color, 1);
`endif

        cyc(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
